// File: rtl/ariane_pkg.sv
// Shared LSU types and default depths for the commit-side store queue.
// Used by commit_stq_ring and commit_store_queue.
package ariane_pkg;

    typedef struct packed {
        logic [63:0] paddr;
        logic [63:0] data;
        logic [7:0]  be;
    } stq_entry_t;

    localparam int unsigned STQ_SPEC_DEPTH   = 4;
    localparam int unsigned STQ_COMMIT_DEPTH = 4;

endpackage

// File: rtl/commit_stq_ring.sv
// Circular store buffer with push/pop/clear, head read-out and per-entry valids.
// Clear wins over a same-cycle push; a same-cycle pop is applied first.
module commit_stq_ring
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    clear_i,
    input  stq_entry_t              data_i,
    output stq_entry_t              head_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [DEPTH-1:0]        valid_o,
    output stq_entry_t [DEPTH-1:0]  mem_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    stq_entry_t [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [PW-1:0]          rd_q, rd_d;
    logic [PW-1:0]          wr_q, wr_d;
    logic [PW:0]            cnt_q, cnt_d;

    always_comb begin
        rd_d    = rd_q + PW'(pop_i);
        wr_d    = wr_q + PW'(push_i);
        cnt_d   = cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        valid_d = valid_q;
        if (pop_i) begin
            valid_d[rd_q] = 1'b0;
        end
        if (push_i) begin
            valid_d[wr_q] = 1'b1;
        end
        // Whatever survives the pop is discarded; the ring restarts at the new head.
        if (clear_i) begin
            wr_d    = rd_d;
            cnt_d   = '0;
            valid_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q   <= '0;
            valid_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            if (push_i && !clear_i) begin
                mem_q[wr_q] <= data_i;
            end
            valid_q <= valid_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign head_o  = empty_o ? '0 : mem_q[rd_q];
    assign valid_o = valid_q;
    assign mem_o   = mem_q;

endmodule

// File: rtl/commit_store_queue.sv
// Speculative + commit store queues feeding the D$ write port in order.
// Optional load page-offset conflict check: define COMMIT_STQ_FWD_EN.
module commit_store_queue
    import ariane_pkg::*;
#(
    parameter int unsigned SPEC_DEPTH   = STQ_SPEC_DEPTH,
    parameter int unsigned COMMIT_DEPTH = STQ_COMMIT_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        valid_i,
    input  logic [63:0] paddr_i,
    input  logic [63:0] data_i,
    input  logic [7:0]  be_i,
    output logic        ready_o,
    input  logic        commit_i,
    output logic        commit_ready_o,
    output logic        no_st_pending_o,
    output logic        req_o,
    output logic [63:0] addr_o,
    output logic [63:0] wdata_o,
    output logic [7:0]  be_o,
    input  logic        gnt_i,
    input  logic [11:0] page_offset_i,
    output logic        page_offset_match_o
);

    stq_entry_t                    spec_in, spec_head, cmt_head;
    stq_entry_t [SPEC_DEPTH-1:0]   spec_mem;
    stq_entry_t [COMMIT_DEPTH-1:0] cmt_mem;
    logic [SPEC_DEPTH-1:0]         spec_vld;
    logic [COMMIT_DEPTH-1:0]       cmt_vld;
    logic spec_full, spec_empty;
    logic cmt_full, cmt_empty;
    logic cmt_pop;

    assign spec_in = '{paddr: paddr_i, data: data_i, be: be_i};
    assign cmt_pop = !cmt_empty && gnt_i;

    commit_stq_ring #(.DEPTH(SPEC_DEPTH)) i_spec (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (valid_i),
        .pop_i   (commit_i),
        .clear_i (flush_i),
        .data_i  (spec_in),
        .head_o  (spec_head),
        .full_o  (spec_full),
        .empty_o (spec_empty),
        .valid_o (spec_vld),
        .mem_o   (spec_mem)
    );

    commit_stq_ring #(.DEPTH(COMMIT_DEPTH)) i_commit (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (commit_i),
        .pop_i   (cmt_pop),
        .clear_i (1'b0),
        .data_i  (spec_head),
        .head_o  (cmt_head),
        .full_o  (cmt_full),
        .empty_o (cmt_empty),
        .valid_o (cmt_vld),
        .mem_o   (cmt_mem)
    );

    assign ready_o         = !spec_full;
    assign commit_ready_o  = !cmt_full;
    assign no_st_pending_o = cmt_empty;
    assign req_o           = !cmt_empty;
    assign addr_o          = cmt_head.paddr;
    assign wdata_o         = cmt_head.data;
    assign be_o            = cmt_head.be;

`ifdef COMMIT_STQ_FWD_EN
    logic match;
    logic unused_lo;

    always_comb begin
        match = 1'b0;
        for (int i = 0; i < SPEC_DEPTH; i++) begin
            if (spec_vld[i] && spec_mem[i].paddr[11:3] == page_offset_i[11:3]) begin
                match = 1'b1;
            end
        end
        for (int i = 0; i < COMMIT_DEPTH; i++) begin
            if (cmt_vld[i] && cmt_mem[i].paddr[11:3] == page_offset_i[11:3]) begin
                match = 1'b1;
            end
        end
    end

    assign unused_lo           = ^page_offset_i[2:0];
    assign page_offset_match_o = match;
`else
    logic unused_fwd;
    assign unused_fwd = ^{page_offset_i, spec_vld, cmt_vld, spec_mem, cmt_mem};
    assign page_offset_match_o = 1'b0;
`endif

`ifndef SYNTHESIS
    a_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        valid_i |-> ready_o)
        else $error("store pushed while speculative queue full");
    a_commit_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        commit_i |-> !spec_empty)
        else $error("commit with empty speculative queue");
    a_commit_full: assert property (@(posedge clk_i) disable iff (rst_i)
        commit_i |-> commit_ready_o)
        else $error("commit while commit queue full");
`endif

endmodule

// File: tb/tb_commit_store_queue.sv
// Directed self-checking bench for commit_store_queue.
// Forwarding checks switch with COMMIT_STQ_FWD_EN.
module tb_commit_store_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic [63:0] paddr = '0;
    logic [63:0] data = '0;
    logic [7:0]  be = '0;
    logic        ready;
    logic        commit = 1'b0;
    logic        commit_ready;
    logic        nsp;
    logic        req;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be_w;
    logic        gnt = 1'b0;
    logic [11:0] poff = '0;
    logic        match;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    commit_store_queue dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .flush_i             (flush),
        .valid_i             (valid),
        .paddr_i             (paddr),
        .data_i              (data),
        .be_i                (be),
        .ready_o             (ready),
        .commit_i            (commit),
        .commit_ready_o      (commit_ready),
        .no_st_pending_o     (nsp),
        .req_o               (req),
        .addr_o              (addr),
        .wdata_o             (wdata),
        .be_o                (be_w),
        .gnt_i               (gnt),
        .page_offset_i       (poff),
        .page_offset_match_o (match)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_commit_ready", commit_ready, 1);
        chk("rst_nsp", nsp, 1);
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_be", be_w, 0);
        chk("rst_match", match, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // four speculative stores, nothing committed
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            paddr = 64'h1000 + 64'(8 * i);
            data  = 64'hD0D0_0000_0000_0000 + 64'(i);
            be    = 8'hF0 | 8'(i);
            step();
            valid = 1'b0;
            chk("fill_ready", ready, (i < 3) ? 1 : 0);
            chk("fill_req", req, 0);
        end
        chk("fill_nsp", nsp, 1);

        // commit all four with gnt held high
        gnt    = 1'b1;
        commit = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("drain_req", req, 1);
            chk("drain_addr", addr, 64'h1000 + 64'(8 * i));
            chk("drain_wdata", wdata, 64'hD0D0_0000_0000_0000 + 64'(i));
            chk("drain_be", be_w, 8'hF0 | 8'(i));
            chk("drain_nsp", nsp, 0);
            if (i == 3) commit = 1'b0;
            step();
        end
        chk("drain_done_req", req, 0);
        chk("drain_done_nsp", nsp, 1);
        chk("drain_done_ready", ready, 1);
        gnt = 1'b0;

        // push 3, commit+flush together
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            paddr = 64'h3000 + 64'(8 * i);
            data  = 64'h3333_0000 + 64'(i);
            be    = 8'hFF;
            step();
        end
        valid  = 1'b0;
        commit = 1'b1;
        flush  = 1'b1;
        step();
        commit = 1'b0;
        flush  = 1'b0;
        chk("flush_ready", ready, 1);
        chk("flush_req", req, 1);
        chk("flush_addr", addr, 64'h3000);
        gnt = 1'b1;
        step();
        chk("flush_one_write", req, 0);
        step();
        chk("flush_no_more", req, 0);
        gnt = 1'b0;
        // freed slots: next push/commit must see the new store, not 0x3008
        valid = 1'b1;
        paddr = 64'h3100;
        data  = 64'h3100;
        step();
        valid  = 1'b0;
        commit = 1'b1;
        step();
        commit = 1'b0;
        chk("flush_head_new", addr, 64'h3100);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("flush_drained", nsp, 1);

        // fill the commit queue with gnt low
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            paddr = 64'h4000 + 64'(8 * i);
            data  = 64'h4444_0000 + 64'(i);
            step();
        end
        valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            commit = 1'b1;
            step();
            chk("cfull_commit_ready", commit_ready, (i < 3) ? 1 : 0);
        end
        commit = 1'b0;
        chk("cfull_ready", ready, 1);
        for (int i = 0; i < 10; i++) begin
            chk("hold_addr", addr, 64'h4000);
            step();
        end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("gnt_commit_ready", commit_ready, 1);
        chk("gnt_next_addr", addr, 64'h4008);

        // reset mid-drain with two left
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("pre_rst_addr", addr, 64'h4010);
        chk("pre_rst_req", req, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", req, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_nsp", nsp, 1);
        chk("mid_rst_commit_ready", commit_ready, 1);
        chk("mid_rst_ready", ready, 1);
        step();
        rst = 1'b0;
        gnt = 1'b1;
        step();
        chk("post_rst_req", req, 0);
        step();
        chk("post_rst_req2", req, 0);
        gnt = 1'b0;

        // page-offset conflict check
        valid = 1'b1;
        paddr = 64'h2A48;
        data  = 64'h2A48;
        step();
        valid = 1'b0;
        poff  = 12'hA4C;
        #1;
`ifdef COMMIT_STQ_FWD_EN
        chk("fwd_spec_hit", match, 1);
        poff = 12'hA50;
        #1;
        chk("fwd_spec_miss", match, 0);
        poff = 12'hA4C;
`else
        chk("nofwd_tied", match, 0);
`endif
        commit = 1'b1;
        step();
        commit = 1'b0;
        #1;
`ifdef COMMIT_STQ_FWD_EN
        chk("fwd_cmt_hit", match, 1);
`else
        chk("nofwd_tied_cmt", match, 0);
`endif
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("fwd_drained_nsp", nsp, 1);
        chk("fwd_drained_match", match, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
